alu_secuencial: RTL

- Multi-cycle ALU directly upstream of the flag controller.
- Produces the registered result bus plus carryOut, borrowOut and overflow that the flag controller consumes to form its N/Z/C/V word.
- Single-cycle ops: add, sub, logic, shifts. Iterative ops: shift-add multiply, restoring divide/modulo.
- Simple start/valid/busy handshake to the control FSM.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_secuencial_unidad_iterativa.sv | 122 ++++++++++++
 rtl/alu_secuencial.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for alu_secuencial: opcodes, FSM states, iterative-unit modes
// and the latency constants of the simple and iterative paths.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_MUL = 4'b0111,
        OP_DIV = 4'b1000,
        OP_MOD = 4'b1001
    } opcode_e;

    typedef enum logic [1:0] {
        REPOSO  = 2'b00,
        CALCULO = 2'b01,
        FIN     = 2'b10
    } estado_e;

    typedef enum logic {
        MODO_MUL = 1'b0,
        MODO_DIV = 1'b1
    } modo_e;

    localparam int LAT_SIMPLE = 1;

    function automatic int LAT_ITER(input int ancho_i);
        return ancho_i + 2;
    endfunction

endpackage

// File: rtl/alu_secuencial_unidad_iterativa.sv
// Shared shift-add multiplier / restoring divider. The start edge performs the first step,
// then one step per edge; {hi,lo} hold product or {remainder,quotient}. Divider under ALU_DIV_EN.
module unidad_iterativa
    import alu_pkg::*;
#(
    parameter int ancho = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  modo_e        modo,
    input  logic [ancho:0] a,
    input  logic [ancho:0] b,
    output logic [ancho:0] hi,
    output logic [ancho:0] lo,
    output logic         done
);

    localparam int W  = ancho + 1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] ULTIMO = CW'(W - 2);

    logic [ancho:0] acc_q, acc_d;
    logic [ancho:0] sh_q, sh_d;
    logic [ancho:0] opnd_q, opnd_d;
    modo_e          modo_q, modo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           run_q, run_d;

    logic [ancho:0] src_acc_s, src_sh_s, src_opnd_s;
    modo_e          src_modo_s;
    logic [W:0]     mul_sum_s;
`ifdef ALU_DIV_EN
    logic [W:0]     div_sh_s, div_dif_s;
`endif

    assign hi   = acc_q;
    assign lo   = sh_q;
    assign done = run_q && (cnt_q == ULTIMO);

    // Step source is the fresh operands on start, otherwise the working registers.
    always_comb begin
        if (start) begin
            src_acc_s  = {W{1'b0}};
            src_sh_s   = a;
            src_opnd_s = b;
            src_modo_s = modo;
        end else begin
            src_acc_s  = acc_q;
            src_sh_s   = sh_q;
            src_opnd_s = opnd_q;
            src_modo_s = modo_q;
        end

        mul_sum_s = {1'b0, src_acc_s} + (src_sh_s[0] ? {1'b0, src_opnd_s} : {(W+1){1'b0}});
`ifdef ALU_DIV_EN
        div_sh_s  = {src_acc_s, src_sh_s[ancho]};
        div_dif_s = div_sh_s - {1'b0, src_opnd_s};
`endif

        acc_d  = acc_q;
        sh_d   = sh_q;
        opnd_d = src_opnd_s;
        modo_d = src_modo_s;
        cnt_d  = cnt_q;
        run_d  = run_q;

        if (start) begin
            cnt_d = {CW{1'b0}};
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + CW'(1'b1);
            run_d = (cnt_q != ULTIMO);
        end else begin
            run_d = 1'b0;
        end

        if (start || run_q) begin
            if (src_modo_s == MODO_MUL) begin
                acc_d = mul_sum_s[W:1];
                sh_d  = {mul_sum_s[0], src_sh_s[ancho:1]};
            end else begin
`ifdef ALU_DIV_EN
                // A clear top bit means the trial subtraction did not go negative.
                if (!div_dif_s[W]) begin
                    acc_d = div_dif_s[ancho:0];
                    sh_d  = {src_sh_s[ancho-1:0], 1'b1};
                end else begin
                    acc_d = div_sh_s[ancho:0];
                    sh_d  = {src_sh_s[ancho-1:0], 1'b0};
                end
`else
                acc_d = acc_q;
                sh_d  = sh_q;
`endif
            end
        end else begin
            acc_d = acc_q;
            sh_d  = sh_q;
        end
    end

    // Working registers of the iterative datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= {W{1'b0}};
            sh_q   <= {W{1'b0}};
            opnd_q <= {W{1'b0}};
            modo_q <= MODO_MUL;
            cnt_q  <= {CW{1'b0}};
            run_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            opnd_q <= opnd_d;
            modo_q <= modo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/alu_secuencial.sv
// Multi-cycle ALU feeding the flag controller: single-cycle ops, iterative MUL and
// (with ALU_DIV_EN defined) DIV/MOD, start/valid/busy handshake, registered outputs.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int ancho = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inicio,
    input  logic [3:0]     opcode,
    input  logic [ancho:0] a,
    input  logic [ancho:0] b,
    output logic [ancho:0] resultado,
    output logic           carryOut,
    output logic           borrowOut,
    output logic           overflow,
    output logic           error,
    output logic           valido,
    output logic           ocupado
);

    localparam int W = ancho + 1;

    estado_e        estado_q, estado_d;
    logic [3:0]     op_q, op_d;
    logic [ancho:0] resultado_q, resultado_d;
    logic           carry_q, carry_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;
    logic           error_q, error_d;
    logic           valido_q, valido_d;
    logic           ocupado_q, ocupado_d;

    logic [ancho:0] res_s;
    logic           carry_s, borrow_s, ovf_s, error_s;
    logic           iter_s, escribe_s, start_s;
    modo_e          modo_s;
    logic [W:0]     suma_s, resta_s;
    logic [ancho:0] hi_s, lo_s;
    logic           done_s;

    assign suma_s  = {1'b0, a} + {1'b0, b};
    assign resta_s = {1'b0, a} - {1'b0, b};

    unidad_iterativa #(
        .ancho (ancho)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .modo  (modo_s),
        .a     (a),
        .b     (b),
        .hi    (hi_s),
        .lo    (lo_s),
        .done  (done_s)
    );

    // Next-state, result selection and output update for accept and FIN edges.
    always_comb begin
        estado_d    = estado_q;
        op_d        = op_q;
        resultado_d = resultado_q;
        carry_d     = carry_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        error_d     = error_q;
        valido_d    = 1'b0;
        ocupado_d   = ocupado_q;
        res_s       = {W{1'b0}};
        carry_s     = 1'b0;
        borrow_s    = 1'b0;
        ovf_s       = 1'b0;
        error_s     = 1'b0;
        iter_s      = 1'b0;
        escribe_s   = 1'b0;
        start_s     = 1'b0;
        modo_s      = MODO_MUL;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    op_d      = opcode;
                    escribe_s = 1'b1;
                    case (opcode)
                        OP_ADD: begin
                            res_s   = suma_s[ancho:0];
                            carry_s = suma_s[W];
                            ovf_s   = (a[ancho] == b[ancho]) && (suma_s[ancho] != a[ancho]);
                        end
                        OP_SUB: begin
                            res_s    = resta_s[ancho:0];
                            borrow_s = resta_s[W];
                            ovf_s    = (a[ancho] != b[ancho]) && (resta_s[ancho] != a[ancho]);
                        end
                        OP_AND: res_s = a & b;
                        OP_OR:  res_s = a | b;
                        OP_XOR: res_s = a ^ b;
                        OP_SHL: begin
                            res_s   = {a[ancho-1:0], 1'b0};
                            carry_s = a[ancho];
                        end
                        OP_SHR: begin
                            res_s   = {1'b0, a[ancho:1]};
                            carry_s = a[0];
                        end
                        OP_MUL: iter_s = 1'b1;
`ifdef ALU_DIV_EN
                        OP_DIV, OP_MOD: begin
                            // Divide by zero is resolved at accept without starting the divider.
                            if (b == {W{1'b0}}) begin
                                error_s = 1'b1;
                                res_s   = (opcode == OP_DIV) ? {W{1'b1}} : a;
                            end else begin
                                iter_s = 1'b1;
                                modo_s = MODO_DIV;
                            end
                        end
`endif
                        default: error_s = 1'b1;
                    endcase
                    if (iter_s) begin
                        start_s   = 1'b1;
                        escribe_s = 1'b0;
                        estado_d  = CALCULO;
                        ocupado_d = 1'b1;
                    end else begin
                        estado_d = REPOSO;
                    end
                end else begin
                    estado_d = REPOSO;
                end
            end
            CALCULO: begin
                if (done_s) begin
                    estado_d = FIN;
                end else begin
                    estado_d = CALCULO;
                end
            end
            FIN: begin
                estado_d  = REPOSO;
                ocupado_d = 1'b0;
                escribe_s = 1'b1;
                case (op_q)
                    OP_MUL: begin
                        res_s   = lo_s;
                        carry_s = |hi_s;
                        ovf_s   = |hi_s;
                    end
`ifdef ALU_DIV_EN
                    OP_DIV: res_s = lo_s;
                    OP_MOD: res_s = hi_s;
`endif
                    default: error_s = 1'b1;
                endcase
            end
            default: begin
                estado_d  = REPOSO;
                ocupado_d = 1'b0;
            end
        endcase

        if (escribe_s) begin
            resultado_d = res_s;
            carry_d     = carry_s;
            borrow_d    = borrow_s;
            ovf_d       = ovf_s;
            error_d     = error_s;
            valido_d    = 1'b1;
        end else begin
            valido_d = 1'b0;
        end
    end

    // FSM state, captured opcode and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= REPOSO;
            op_q        <= 4'b0000;
            resultado_q <= {W{1'b0}};
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            error_q     <= 1'b0;
            valido_q    <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            op_q        <= op_d;
            resultado_q <= resultado_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            error_q     <= error_d;
            valido_q    <= valido_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign resultado = resultado_q;
    assign carryOut  = carry_q;
    assign borrowOut = borrow_q;
    assign overflow  = ovf_q;
    assign error     = error_q;
    assign valido    = valido_q;
    assign ocupado   = ocupado_q;

endmodule
